// File: rtl/ram_bus_bridge.sv
// Bridges the MEM stage's single-cycle RAM request onto a registered req/ready bus.
// The pipeline is stalled until the slave answers or the timeout ends the transaction.
module ram_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        stall_req,
    output logic        bus_req,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          timeout;

    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ram_en) state_nxt = REQ;
            REQ:     if (bus_ready || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst so the pipeline is released the instant reset is raised.
    always_comb begin
        stall_req = 1'b0;
        if (!rst)
            stall_req = (state == IDLE && ram_en) || (state == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req       <= 1'b0;
            bus_we        <= 4'b0000;
            bus_addr      <= 32'h0;
            bus_wdata     <= 32'h0;
            ram_read_data <= 32'h0;
            bus_err       <= 1'b0;
            cnt           <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ram_en) begin
                        bus_we    <= ram_write_en;
                        bus_addr  <= ram_addr;
                        bus_wdata <= ram_write_data;
                        bus_req   <= 1'b1;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    // A ready in the final timeout cycle still counts as a normal completion.
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (bus_we == 4'b0000) ram_read_data <= bus_rdata;
                    end else if (timeout) begin
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (bus_we == 4'b0000) ram_read_data <= ERR_RDATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    bus_req <= 1'b0;
                default: bus_req <= 1'b0;
            endcase
        end
    end

endmodule
